// File: rtl/do_channel_ctrl.sv
// ---------------------------------------------------------------------------
// do_channel_ctrl
//
// Controller for one digital-output channel. The host commands the output
// level; the controller drives it, watches the readback line and, at a fixed
// interval, inverts the output for a short pulse to prove that the readback
// path is live. Stuck-high / stuck-low readback is latched in sticky flags.
//
// Sequence: SETTLE -> HOLD -> PULSE -> RESTORE -> HOLD ...
//   SETTLE  : output = commanded level, no comparison (readback settling)
//   HOLD    : output = commanded level, filtered continuous comparison
//   PULSE   : output inverted, readback sampled on the last pulse cycle
//   RESTORE : output = commanded level, no comparison; pending command applied
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cmd_valid     : one-cycle strobe loading cmd_value as the commanded level
//   cmd_value     : commanded output level
//   test_en       : enables the periodic self-test pulse
//   fault_clr     : one-cycle strobe clearing both sticky fault flags
//   din_feedback  : asynchronous readback from the channel
//   fp_channel    : channel drive (registered)
//   fd_channel    : fault-drive line, tied low
//   out_state     : registered commanded level
//   fault_hi      : sticky, readback 1 while 0 expected
//   fault_lo      : sticky, readback 0 while 1 expected
//   test_done     : one-cycle pulse after a clean self-test window
//   busy          : high in every state except HOLD
// ---------------------------------------------------------------------------
module do_channel_ctrl #(
  parameter int SETTLE_CYC  = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TEST_PERIOD = 1000,
  parameter int FILT_CYC    = 3,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_value,
  input  logic test_en,
  input  logic fault_clr,
  input  logic din_feedback,
  output logic fp_channel,
  output logic fd_channel,
  output logic out_state,
  output logic fault_hi,
  output logic fault_lo,
  output logic test_done,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PULSE   = 2'd2,
    ST_RESTORE = 2'd3
  } state_t;

  // Terminal counter values; every counter stops and transitions here.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(TEST_PERIOD - 1);
  localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(FILT_CYC - 1);

  // Saturating increment: a counter never wraps past its terminal value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    return (c >= lim) ? c : c + CNT_W'(1);
  endfunction

  // Feedback synchronizer
  logic fb_p0;
  logic fb_s;

  // Control state
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;     // settle / pulse / restore timer
  logic [CNT_W-1:0] mcnt_q, mcnt_nxt;   // consecutive mismatch count in HOLD
  logic [CNT_W-1:0] pcnt_q, pcnt_nxt;   // self-test period timer in HOLD
  logic             out_state_q, out_nxt;
  logic             pend_vld_q, pend_vld_nxt;
  logic             pend_val_q, pend_val_nxt;
  logic             fault_hi_q, fault_hi_nxt;
  logic             fault_lo_q, fault_lo_nxt;
  logic             test_done_q, done_nxt;
  logic             fp_q, fp_nxt;

  logic set_hi;
  logic set_lo;
  logic cmd_chg;
  logic eff_vld;
  logic eff_val;

  // A command only matters when it changes the level.
  assign cmd_chg = cmd_valid && (cmd_value != out_state_q);

  // Pending command as seen this cycle: a command arriving on the last
  // RESTORE cycle overwrites the stored one before it is applied.
  assign eff_vld = cmd_valid | pend_vld_q;
  assign eff_val = cmd_valid ? cmd_value : pend_val_q;

  // ---- stage p0/p1: two-flop readback synchronizer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_p0 <= 1'b0;
      fb_s  <= 1'b0;
    end else begin
      fb_p0 <= din_feedback;
      fb_s  <= fb_p0;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    mcnt_nxt     = '0;
    pcnt_nxt     = pcnt_q;
    out_nxt      = out_state_q;
    pend_vld_nxt = pend_vld_q;
    pend_val_nxt = pend_val_q;
    set_hi       = 1'b0;
    set_lo       = 1'b0;
    done_nxt     = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (cmd_chg) begin
          out_nxt  = cmd_value;
          cnt_nxt  = '0;
          pcnt_nxt = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          pcnt_nxt  = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q, SETTLE_LAST);
        end
      end

      ST_HOLD: begin
        // Filtered comparison; a matching cycle leaves mcnt at its 0 default.
        if (fb_s != out_state_q) begin
          if (mcnt_q == FILT_LAST) begin
            set_hi   = ~out_state_q;
            set_lo   = out_state_q;
            mcnt_nxt = '0;
          end else begin
            mcnt_nxt = sat_inc(mcnt_q, FILT_LAST);
          end
        end

        if (cmd_chg) begin
          out_nxt   = cmd_value;
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
          mcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end else if (test_en) begin
          if (pcnt_q == PERIOD_LAST) begin
            state_nxt = ST_PULSE;
            cnt_nxt   = '0;
            mcnt_nxt  = '0;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = sat_inc(pcnt_q, PERIOD_LAST);
          end
        end else begin
          pcnt_nxt = '0;
        end
      end

      ST_PULSE: begin
        if (cmd_valid) begin
          pend_vld_nxt = 1'b1;
          pend_val_nxt = cmd_value;
        end
        if (cnt_q == PULSE_LAST) begin
          // Output is ~out_state here; readback equal to out_state means the
          // inverted level never reached the pin.
          if (fb_s == out_state_q) begin
            set_lo = ~out_state_q;
            set_hi = out_state_q;
          end else begin
            done_nxt = 1'b1;
          end
          state_nxt = ST_RESTORE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q, PULSE_LAST);
        end
      end

      ST_RESTORE: begin
        pend_vld_nxt = eff_vld;
        pend_val_nxt = eff_val;
        if (cnt_q == SETTLE_LAST) begin
          pend_vld_nxt = 1'b0;
          cnt_nxt      = '0;
          pcnt_nxt     = '0;
          if (eff_vld && (eff_val != out_state_q)) begin
            out_nxt   = eff_val;
            state_nxt = ST_SETTLE;
          end else begin
            state_nxt = ST_HOLD;
          end
        end else begin
          cnt_nxt = sat_inc(cnt_q, SETTLE_LAST);
        end
      end

      default: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
        pcnt_nxt  = '0;
      end
    endcase

    // Set wins over a simultaneous clear.
    fault_hi_nxt = set_hi | (fault_hi_q & ~fault_clr);
    fault_lo_nxt = set_lo | (fault_lo_q & ~fault_clr);

    // Drive registered from next-state so the pin changes with the state.
    fp_nxt = (state_nxt == ST_PULSE) ? ~out_nxt : out_nxt;
  end

  // ---- stage p2: control and output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      mcnt_q      <= '0;
      pcnt_q      <= '0;
      out_state_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_val_q  <= 1'b0;
      fault_hi_q  <= 1'b0;
      fault_lo_q  <= 1'b0;
      test_done_q <= 1'b0;
      fp_q        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      mcnt_q      <= mcnt_nxt;
      pcnt_q      <= pcnt_nxt;
      out_state_q <= out_nxt;
      pend_vld_q  <= pend_vld_nxt;
      pend_val_q  <= pend_val_nxt;
      fault_hi_q  <= fault_hi_nxt;
      fault_lo_q  <= fault_lo_nxt;
      test_done_q <= done_nxt;
      fp_q        <= fp_nxt;
    end
  end

  assign fp_channel = fp_q;
  assign fd_channel = 1'b0;
  assign out_state  = out_state_q;
  assign fault_hi   = fault_hi_q;
  assign fault_lo   = fault_lo_q;
  assign test_done  = test_done_q;
  assign busy       = (state_q != ST_HOLD);

endmodule
